// File: rtl/sal_rd_resp_fmt.sv
// sal_rd_resp_fmt: AXI read-response formatter. Queues AR burst lengths in
// order, counts returned beats to build rlast, and registers the R path
// through a 2-entry (main + skid) buffer.
// Ports: clk/rst_n (sync, active-low); ar_push_i/ar_len_i/ar_full_o length
// queue; in_r* beats from the read controller; m_r* AXI R channel to the
// master; err_ovf_o sticky push-while-full flag.
module sal_rd_resp_fmt #(
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int LEN_DEPTH_LG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_push_i,
  input  logic [7:0]            ar_len_i,
  output logic                  ar_full_o,
  input  logic                  in_rvalid_i,
  output logic                  in_rready_o,
  input  logic [ID_WIDTH-1:0]   in_rid_i,
  input  logic [DATA_WIDTH-1:0] in_rdata_i,
  input  logic [1:0]            in_rresp_i,
  output logic                  m_rvalid_o,
  input  logic                  m_rready_i,
  output logic [ID_WIDTH-1:0]   m_rid_o,
  output logic [DATA_WIDTH-1:0] m_rdata_o,
  output logic [1:0]            m_rresp_o,
  output logic                  m_rlast_o,
  output logic                  err_ovf_o
);

  localparam int PW    = LEN_DEPTH_LG2 + 1;
  localparam int DEPTH = 1 << LEN_DEPTH_LG2;

  logic [7:0]    len_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, rd_nxt;
  logic          full_q, err_q;
  logic          len_empty, push_ok, pop;
  logic [7:0]    len_head, beat_cnt;
  logic          accept, is_last;

  logic                  main_valid, main_last;
  logic [ID_WIDTH-1:0]   main_id;
  logic [DATA_WIDTH-1:0] main_data;
  logic [1:0]            main_resp;
  logic                  skid_valid, skid_last;
  logic [ID_WIDTH-1:0]   skid_id;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [1:0]            skid_resp;

  assign len_empty = (wr_ptr == rd_ptr);
  assign push_ok   = ar_push_i & ~full_q;
  assign len_head  = len_mem[rd_ptr[PW-2:0]];

  // Ready depends only on local state, so no comb path from m_rready_i.
  assign in_rready_o = ~skid_valid & ~len_empty;
  assign accept      = in_rvalid_i & in_rready_o;
  assign is_last     = (beat_cnt == len_head);
  assign pop         = accept & is_last;

  assign wr_nxt = wr_ptr + {{(PW-1){1'b0}}, push_ok};
  assign rd_nxt = rd_ptr + {{(PW-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) len_mem[wr_ptr[PW-2:0]] <= ar_len_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      // Full flag computed from next-state pointers so it is a flop.
      full_q <= (wr_nxt[PW-1] != rd_nxt[PW-1]) &&
                (wr_nxt[PW-2:0] == rd_nxt[PW-2:0]);
      err_q  <= err_q | (ar_push_i & full_q);
      if (accept) beat_cnt <= is_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_last  <= 1'b0;
      main_id    <= '0;
      main_data  <= '0;
      main_resp  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_id    <= '0;
      skid_data  <= '0;
      skid_resp  <= '0;
    end else begin
      if (accept && (!main_valid || m_rready_i)) begin
        main_valid <= 1'b1;
        main_last  <= is_last;
        main_id    <= in_rid_i;
        main_data  <= in_rdata_i;
        main_resp  <= in_rresp_i;
      end else if (m_rready_i && skid_valid) begin
        main_valid <= 1'b1;
        main_last  <= skid_last;
        main_id    <= skid_id;
        main_data  <= skid_data;
        main_resp  <= skid_resp;
        skid_valid <= 1'b0;
      end else if (m_rready_i) begin
        main_valid <= 1'b0;
      end
      // Accept only happens with an empty skid, so no overwrite here.
      if (accept && main_valid && !m_rready_i) begin
        skid_valid <= 1'b1;
        skid_last  <= is_last;
        skid_id    <= in_rid_i;
        skid_data  <= in_rdata_i;
        skid_resp  <= in_rresp_i;
      end
    end
  end

  assign ar_full_o  = full_q;
  assign err_ovf_o  = err_q;
  assign m_rvalid_o = main_valid;
  assign m_rlast_o  = main_last;
  assign m_rid_o    = main_id;
  assign m_rdata_o  = main_data;
  assign m_rresp_o  = main_resp;

endmodule
